// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, widths and the sequencer state type,
// plus the bit-permutation helpers used by the round datapath.
package des_pkg;

  localparam int BLOCK_W = 64;
  localparam int HALF_W  = 32;
  localparam int KEY_W   = 48;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Tables use DES bit numbering: position 1 is the most significant bit.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] q;
    for (int i = 0; i < BLOCK_W; i++) q[6'(BLOCK_W-1-i)] = d[6'(BLOCK_W-IP_T[i])];
    return q;
  endfunction

  function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] q;
    for (int i = 0; i < BLOCK_W; i++) q[6'(BLOCK_W-1-i)] = d[6'(BLOCK_W-FP_T[i])];
    return q;
  endfunction

  function automatic logic [KEY_W-1:0] e_expand(input logic [HALF_W-1:0] d);
    logic [KEY_W-1:0] q;
    for (int i = 0; i < KEY_W; i++) q[6'(KEY_W-1-i)] = d[5'(HALF_W-E_T[i])];
    return q;
  endfunction

  function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] d);
    logic [HALF_W-1:0] q;
    for (int i = 0; i < HALF_W; i++) q[5'(HALF_W-1-i)] = d[5'(HALF_W-P_T[i])];
    return q;
  endfunction

  // Outer bits pick the row, inner four bits the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] b);
    return SBOX[n][{b[5], b[0], b[4:1]}];
  endfunction

endpackage

// File: rtl/des_round_sequencer_if.sv
// Block I/O, subkey fetch and control bundle of the iterative DES sequencer.
interface des_round_sequencer_if import des_pkg::*; #(
  parameter int KEY_IDX_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BLOCK_W-1:0]   plntxt;
  logic                 decrypt;
  logic [KEY_IDX_W-1:0] key_idx;
  logic [KEY_W-1:0]     subkey;
  logic                 out_valid;
  logic                 out_ready;
  logic [BLOCK_W-1:0]   cphrtxt;
  logic                 flush;
  logic                 busy;

  modport slave (
    input  in_valid, plntxt, decrypt, subkey, out_ready, flush,
    output in_ready, key_idx, out_valid, cphrtxt, busy
  );

  modport master (
    output in_valid, plntxt, decrypt, subkey, out_ready, flush,
    input  in_ready, key_idx, out_valid, cphrtxt, busy
  );
endinterface

// File: rtl/des_f_function.sv
// DES round function f(R,K) = P(S(E(R) ^ K)), purely combinational.
module des_f_function import des_pkg::*; (
  input  logic [HALF_W-1:0] r,
  input  logic [KEY_W-1:0]  k,
  output logic [HALF_W-1:0] f
);
  logic [KEY_W-1:0]  x;
  logic [HALF_W-1:0] s_out;

  assign x = e_expand(r) ^ k;

  for (genvar i = 0; i < 8; i++) begin : g_sbox
    assign s_out[HALF_W-1-4*i -: 4] = sbox_lookup(3'(i), x[KEY_W-1-6*i -: 6]);
  end

  assign f = p_perm(s_out);
endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES: one Feistel round per clock, subkeys fetched by index from an external store,
// result held until the consumer takes it.
module des_round_sequencer import des_pkg::*; #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_IDX_W  = 4
) (
  input logic clk,
  input logic rst,
  des_round_sequencer_if.slave bus
);
  localparam logic [KEY_IDX_W-1:0] LAST = KEY_IDX_W'(NUM_ROUNDS - 1);

  state_t               state;
  logic [KEY_IDX_W-1:0] rnd;
  logic                 dec_r;
  logic [HALF_W-1:0]    l_half, r_half;
  logic [HALF_W-1:0]    f_out, l_new, r_new;
  logic [BLOCK_W-1:0]   ip_in;
  logic [BLOCK_W-1:0]   cphrtxt_r;
  logic                 out_valid_r, busy_r;
  logic                 accept;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.key_idx   = (state == RUN) ? (dec_r ? LAST - rnd : rnd) : '0;
  assign bus.out_valid = out_valid_r;
  assign bus.cphrtxt   = cphrtxt_r;
  assign bus.busy      = busy_r;

  assign ip_in = ip_perm(bus.plntxt);

  des_f_function u_f (
    .r (r_half),
    .k (bus.subkey),
    .f (f_out)
  );

  assign l_new = r_half;
  assign r_new = l_half ^ f_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rnd         <= '0;
      dec_r       <= 1'b0;
      l_half      <= '0;
      r_half      <= '0;
      cphrtxt_r   <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      rnd         <= '0;
      cphrtxt_r   <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            {l_half, r_half} <= ip_in;
            dec_r  <= bus.decrypt;
            rnd    <= '0;
            state  <= RUN;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          l_half <= l_new;
          r_half <= r_new;
          rnd    <= rnd + 1'b1;
          // Swapping the halves into FP undoes the swap of the last round.
          if (rnd == LAST) begin
            cphrtxt_r   <= fp_perm({r_new, l_new});
            out_valid_r <= 1'b1;
            state       <= DONE;
            busy_r      <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (accept) begin
              {l_half, r_half} <= ip_in;
              dec_r  <= bus.decrypt;
              rnd    <= '0;
              state  <= RUN;
              busy_r <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
